// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Fabric-side supervisor for the PLL_148M5 instance. Pulses the PLL reset,
//   waits for lock with a timeout and a limited number of retries, requires
//   lock to hold for LOCK_STABLE cycles before releasing the downstream reset,
//   counts lock losses, and applies runtime output-divider/duty changes through
//   a cfg_req/cfg_ack handshake. Runs on the 50 MHz board reference because
//   the PLL outputs cannot be trusted before lock.
//
// Ports
//   clkin1        in   50 MHz reference clock (only clock)
//   pll_rst_in    in   asynchronous active-high block reset
//   pll_lock      in   PLL lock, asynchronous to clkin1
//   cfg_req       in   level request; held high by the requester until cfg_ack
//   cfg_odiv0     in   [9:0] requested output divider
//   cfg_duty0     in   [9:0] requested duty setting
//   cfg_ack       out  one-cycle pulse when a requested config reaches RUN
//   pll_rst       out  active-high reset to the PLL
//   dyn_odiv0     out  [9:0] dynamic divider to the PLL
//   dyn_duty0     out  [9:0] dynamic duty to the PLL
//   user_rst      out  active-high reset to downstream logic
//   locked        out  high only in RUN
//   fault         out  high only in FAULT
//   retry_cnt     out  [1:0] lock timeouts since the last RUN (MAX_RETRIES <= 3)
//   lock_loss_cnt out  [7:0] lock losses seen in RUN, saturating at 255

module pll_lock_supervisor #(
    parameter int unsigned RST_HOLD_CYCLES = 10,
    parameter int unsigned LOCK_TIMEOUT    = 50000,
    parameter int unsigned LOCK_STABLE     = 1024,
    parameter int unsigned MAX_RETRIES     = 3,
    parameter int unsigned ODIV0_INIT      = 100,
    parameter int unsigned DUTY0_INIT      = 100
) (
    input  logic       clkin1,
    input  logic       pll_rst_in,
    input  logic       pll_lock,
    input  logic       cfg_req,
    input  logic [9:0] cfg_odiv0,
    input  logic [9:0] cfg_duty0,
    output logic       cfg_ack,
    output logic       pll_rst,
    output logic [9:0] dyn_odiv0,
    output logic [9:0] dyn_duty0,
    output logic       user_rst,
    output logic       locked,
    output logic       fault,
    output logic [1:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    // One shared cycle counter serves the reset hold, lock timeout and
    // stability window; it is sized for the largest of the three.
    localparam int unsigned CNT_A   = (RST_HOLD_CYCLES > LOCK_TIMEOUT) ? RST_HOLD_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned CNT_MAX = (CNT_A > LOCK_STABLE) ? CNT_A : LOCK_STABLE;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);

    typedef enum logic [2:0] {
        RESET_HOLD,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    lock_sync;
    logic          lock_s;
    logic          pending;
    logic          ack_arm;

    // Two-flop synchronizer for the asynchronous lock indication.
    always_ff @(posedge clkin1 or posedge pll_rst_in) begin
        if (pll_rst_in) begin
            lock_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[0], pll_lock};
        end
    end

    assign lock_s = lock_sync[1];

    always_ff @(posedge clkin1 or posedge pll_rst_in) begin
        if (pll_rst_in) begin
            state         <= RESET_HOLD;
            cnt           <= '0;
            pending       <= 1'b0;
            ack_arm       <= 1'b0;
            cfg_ack       <= 1'b0;
            pll_rst       <= 1'b1;
            user_rst      <= 1'b1;
            locked        <= 1'b0;
            fault         <= 1'b0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
            dyn_odiv0     <= 10'(ODIV0_INIT);
            dyn_duty0     <= 10'(DUTY0_INIT);
        end else begin
            // Outputs follow the state held during this cycle, so every
            // output change lands one cycle after the transition causing it.
            pll_rst  <= (state == RESET_HOLD) || (state == FAULT);
            user_rst <= (state != RUN);
            locked   <= (state == RUN);
            fault    <= (state == FAULT);
            // ack_arm is set on the RUN entry edge; delaying it once more
            // makes cfg_ack rise together with locked.
            cfg_ack  <= ack_arm;
            ack_arm  <= 1'b0;

            case (state)
                RESET_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                WAIT_LOCK: begin
                    // Lock takes priority over a coincident timeout.
                    if (lock_s) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt       <= '0;
                        retry_cnt <= retry_cnt + 1'b1;
                        if (32'(retry_cnt) + 32'd1 == MAX_RETRIES) begin
                            state <= FAULT;
                        end else begin
                            state <= RESET_HOLD;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STABLE: begin
                    // A dropout restarts the lock wait without costing a
                    // retry; a pending configuration stays pending.
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state     <= RUN;
                        cnt       <= '0;
                        retry_cnt <= '0;
                        ack_arm   <= pending;
                        pending   <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RUN: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                        if (lock_loss_cnt != '1) begin
                            lock_loss_cnt <= lock_loss_cnt + 1'b1;
                        end
                    end else if (cfg_req && !ack_arm && !cfg_ack) begin
                        // The requester still holds cfg_req while the ack for
                        // its own request is in flight; those cycles must not
                        // start a second reconfiguration.
                        dyn_odiv0 <= cfg_odiv0;
                        dyn_duty0 <= cfg_duty0;
                        pending   <= 1'b1;
                        state     <= RESET_HOLD;
                        cnt       <= '0;
                    end
                end

                FAULT: begin
                    if (cfg_req) begin
                        dyn_odiv0 <= cfg_odiv0;
                        dyn_duty0 <= cfg_duty0;
                        retry_cnt <= '0;
                        pending   <= 1'b1;
                        state     <= RESET_HOLD;
                        cnt       <= '0;
                    end
                end

                default: begin
                    state <= RESET_HOLD;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
//   Directed self-checking bench for pll_lock_supervisor with short timing
//   parameters. Inputs change 1 ns after a rising edge; outputs are sampled
//   at the same point, i.e. away from the active edge. Latencies are counted
//   from the first rising edge that samples a new pll_lock value (cycle 0).

module tb_pll_lock_supervisor;

    localparam int unsigned HOLD = 10;
    localparam int unsigned TMO  = 200;
    localparam int unsigned STB  = 16;

    logic       clkin1 = 1'b0;
    logic       pll_rst_in;
    logic       pll_lock;
    logic       cfg_req;
    logic [9:0] cfg_odiv0;
    logic [9:0] cfg_duty0;
    logic       cfg_ack;
    logic       pll_rst;
    logic [9:0] dyn_odiv0;
    logic [9:0] dyn_duty0;
    logic       user_rst;
    logic       locked;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int n_cmp      = 0;
    int n_err      = 0;
    int ack_pulses = 0;

    pll_lock_supervisor #(
        .RST_HOLD_CYCLES(HOLD),
        .LOCK_TIMEOUT   (TMO),
        .LOCK_STABLE    (STB),
        .MAX_RETRIES    (3),
        .ODIV0_INIT     (100),
        .DUTY0_INIT     (100)
    ) dut (
        .clkin1       (clkin1),
        .pll_rst_in   (pll_rst_in),
        .pll_lock     (pll_lock),
        .cfg_req      (cfg_req),
        .cfg_odiv0    (cfg_odiv0),
        .cfg_duty0    (cfg_duty0),
        .cfg_ack      (cfg_ack),
        .pll_rst      (pll_rst),
        .dyn_odiv0    (dyn_odiv0),
        .dyn_duty0    (dyn_duty0),
        .user_rst     (user_rst),
        .locked       (locked),
        .fault        (fault),
        .retry_cnt    (retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #10 clkin1 = ~clkin1;

    // Every cycle with cfg_ack high counts as one ack pulse cycle.
    always @(negedge clkin1) begin
        if (cfg_ack === 1'b1) ack_pulses++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clkin1);
        #1;
    endtask

    task automatic apply_reset();
        pll_rst_in = 1'b1;
        pll_lock   = 1'b0;
        cfg_req    = 1'b0;
        step(2);
        pll_rst_in = 1'b0;
    endtask

    task automatic wait_pll_rst(input logic lvl, input string tag);
        int n;
        n = 0;
        while (pll_rst !== lvl && n < 500) begin
            step(1);
            n++;
        end
        check(tag, int'(pll_rst), int'(lvl));
    endtask

    task automatic wait_locked(input string tag, output int lat);
        int n;
        n = 0;
        while (locked !== 1'b1 && n < 1000) begin
            step(1);
            n++;
        end
        check(tag, int'(locked), 1);
        lat = n - 1;
    endtask

    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        while (cfg_ack !== 1'b1 && n < 1000) begin
            step(1);
            n++;
        end
        check(tag, int'(cfg_ack), 1);
    endtask

    initial begin
        int n;
        int lat;
        int base;
        int pulses;
        logic prev;

        pll_rst_in = 1'b1;
        pll_lock   = 1'b0;
        cfg_req    = 1'b0;
        cfg_odiv0  = '0;
        cfg_duty0  = '0;

        // ---- reset values and power-up ----
        step(2);
        check("rst_pll_rst", int'(pll_rst), 1);
        check("rst_user_rst", int'(user_rst), 1);
        check("rst_locked", int'(locked), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_cfg_ack", int'(cfg_ack), 0);
        check("rst_retry", int'(retry_cnt), 0);
        check("rst_loss", int'(lock_loss_cnt), 0);
        check("rst_odiv0", int'(dyn_odiv0), 100);
        check("rst_duty0", int'(dyn_duty0), 100);

        pll_rst_in = 1'b0;
        n = 0;
        step(1);
        while (pll_rst === 1'b1 && n < 100) begin
            n++;
            step(1);
        end
        check("pwrup_rst_width", n, 10);
        step(49);
        pll_lock = 1'b1;
        wait_locked("pwrup_locked", lat);
        check("pwrup_lock_latency", lat, 2 + 16 + 1);
        check("pwrup_user_rst", int'(user_rst), 0);
        check("pwrup_retry", int'(retry_cnt), 0);
        check("pwrup_no_ack", ack_pulses, 0);

        // ---- 4-cycle lock glitch during STABLE ----
        apply_reset();
        wait_pll_rst(1'b0, "glitch_rst_release");
        pll_lock = 1'b1;
        step(10);
        pll_lock = 1'b0;
        step(4);
        check("glitch_not_locked", int'(locked), 0);
        pll_lock = 1'b1;
        wait_locked("glitch_relocked", lat);
        check("glitch_latency", lat, 19);
        check("glitch_retry", int'(retry_cnt), 0);
        check("glitch_pll_rst", int'(pll_rst), 0);

        // ---- lock losses in RUN ----
        for (int i = 0; i < 3; i++) begin
            pll_lock = 1'b0;
            step(3);
            check("loss_user_rst_early", int'(user_rst), 0);
            step(1);
            check("loss_user_rst", int'(user_rst), 1);
            step(96);
            pll_lock = 1'b1;
            wait_locked("loss_relock", lat);
        end
        check("loss_cnt_3", int'(lock_loss_cnt), 3);
        check("loss_retry", int'(retry_cnt), 0);

        for (int i = 0; i < 252; i++) begin
            pll_lock = 1'b0;
            step(4);
            pll_lock = 1'b1;
            wait_locked("sat_relock", lat);
        end
        check("loss_cnt_255", int'(lock_loss_cnt), 255);
        for (int i = 0; i < 5; i++) begin
            pll_lock = 1'b0;
            step(4);
            pll_lock = 1'b1;
            wait_locked("sat_relock2", lat);
        end
        check("loss_cnt_sat", int'(lock_loss_cnt), 255);

        // ---- reconfiguration from RUN ----
        base      = ack_pulses;
        cfg_odiv0 = 10'd200;
        cfg_duty0 = 10'd200;
        cfg_req   = 1'b1;
        step(1);
        check("cfg_odiv0", int'(dyn_odiv0), 200);
        check("cfg_duty0", int'(dyn_duty0), 200);
        step(1);
        check("cfg_pll_rst", int'(pll_rst), 1);
        check("cfg_user_rst", int'(user_rst), 1);
        pll_lock = 1'b0;
        wait_pll_rst(1'b0, "cfg_rst_release");
        step(20);
        pll_lock = 1'b1;
        pulses = 0;
        prev   = pll_rst;
        n      = 0;
        while (cfg_ack !== 1'b1 && n < 500) begin
            step(1);
            n++;
            if (pll_rst === 1'b1 && prev === 1'b0) pulses++;
            prev = pll_rst;
        end
        check("cfg_ack_seen", int'(cfg_ack), 1);
        check("cfg_ack_with_locked", int'(locked), 1);
        cfg_req = 1'b0;
        step(1);
        check("cfg_ack_one_cycle", int'(cfg_ack), 0);
        check("cfg_still_locked", int'(locked), 1);
        step(30);
        check("cfg_no_restart_locked", int'(locked), 1);
        check("cfg_no_restart_pll_rst", int'(pll_rst), 0);
        check("cfg_extra_pulses", pulses, 0);
        check("cfg_ack_count", ack_pulses - base, 1);
        check("cfg_odiv0_kept", int'(dyn_odiv0), 200);

        // ---- pll_lock tied low: three timeouts into FAULT ----
        apply_reset();
        step(10);
        check("tmo_first_hold", int'(pll_rst), 1);
        step(1);
        check("tmo_first_fall", int'(pll_rst), 0);
        for (int r = 1; r <= 3; r++) begin
            step(199);
            check("tmo_rst_low", int'(pll_rst), 0);
            check("tmo_retry", int'(retry_cnt), r);
            step(1);
            check("tmo_rst_pulse", int'(pll_rst), 1);
            check("tmo_fault", int'(fault), (r == 3) ? 1 : 0);
            if (r < 3) begin
                step(9);
                check("tmo_rst_hold", int'(pll_rst), 1);
                step(1);
                check("tmo_rst_fall", int'(pll_rst), 0);
            end
        end
        step(50);
        check("fault_held", int'(fault), 1);
        check("fault_retry", int'(retry_cnt), 3);
        check("fault_user_rst", int'(user_rst), 1);
        check("fault_pll_rst", int'(pll_rst), 1);
        check("fault_locked", int'(locked), 0);

        // ---- leaving FAULT with cfg_req ----
        base      = ack_pulses;
        cfg_odiv0 = 10'd300;
        cfg_duty0 = 10'd50;
        cfg_req   = 1'b1;
        step(1);
        check("fexit_odiv0", int'(dyn_odiv0), 300);
        check("fexit_duty0", int'(dyn_duty0), 50);
        check("fexit_retry", int'(retry_cnt), 0);
        step(1);
        check("fexit_fault", int'(fault), 0);
        check("fexit_pll_rst", int'(pll_rst), 1);
        wait_pll_rst(1'b0, "fexit_rst_release");
        step(20);
        pll_lock = 1'b1;
        wait_ack("fexit_ack");
        check("fexit_locked", int'(locked), 1);
        cfg_req = 1'b0;
        step(2);
        check("fexit_ack_count", ack_pulses - base, 1);
        check("fexit_retry_run", int'(retry_cnt), 0);

        // ---- block reset during WAIT_LOCK with a request pending ----
        cfg_odiv0 = 10'd400;
        cfg_duty0 = 10'd60;
        cfg_req   = 1'b1;
        step(2);
        check("rmid_pll_rst_pulse", int'(pll_rst), 1);
        pll_lock = 1'b0;
        wait_pll_rst(1'b0, "rmid_wait_lock");
        step(5);
        base = ack_pulses;
        #5 pll_rst_in = 1'b1;
        #1;
        check("rmid_pll_rst", int'(pll_rst), 1);
        check("rmid_user_rst", int'(user_rst), 1);
        check("rmid_locked", int'(locked), 0);
        check("rmid_odiv0", int'(dyn_odiv0), 100);
        check("rmid_duty0", int'(dyn_duty0), 100);
        cfg_req = 1'b0;
        step(2);
        pll_rst_in = 1'b0;
        wait_pll_rst(1'b0, "rmid_rst_release");
        pll_lock = 1'b1;
        wait_locked("rmid_relock", lat);
        step(3);
        check("rmid_no_ack", ack_pulses - base, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
